trap_arb: RTL and testbench
===========================

TRAP_ARB -- requirements
Module: trap_arb

Interface
REQ-001 Parameter NSRC, default 8, number of trap/interrupt request channels (2..16).
REQ-002 Parameter IDW, default $clog2(NSRC), width of winner index.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NSRC  per-channel request pulses; a one-cycle high sets that channel's latch.
REQ-006 nmi  input  NSRC  per-channel non-maskable flag; channel ignores PS priority when set.
REQ-007 lvl  input  3*NSRC  per-channel priority level 0..7, channel i at bits [3i+2:3i].
REQ-008 vec  input  8*NSRC  per-channel vector address bits [9:2], channel i at bits [8i+7:8i].
REQ-009 ps_pl  input  3  current processor priority level.
REQ-010 poll  input  1  microcode service point strobe (end of instruction).
REQ-011 ack  input  1  microcode has taken the offered vector.
REQ-012 clr_all  input  1  bus init; clears all latches.
REQ-013 pending  output  1  any eligible latched channel exists.
REQ-014 offer  output  1  vector valid, awaiting ack.
REQ-015 vector  output  16  offered vector, {6'b0, vec[i], 2'b00}.
REQ-016 win_id  output  IDW  index of offered channel.
REQ-017 latched  output  NSRC  current request latches.

Function
REQ-018 Eligible(i) SHALL be latched[i] & (nmi[i] | lvl[i] > ps_pl), evaluated combinationally.
REQ-019 pending SHALL be the OR of eligible over all channels, combinational.
REQ-020 Winner SHALL be the eligible channel with highest lvl; nmi outranks any non-nmi; ties go to lowest index.
REQ-021 FSM states: IDLE, ARB, OFFER.
REQ-022 IDLE -> ARB on poll & pending; poll with no pending SHALL stay IDLE.
REQ-023 ARB SHALL register winner index and vector, then go to OFFER next cycle (offer asserts 2 cycles after poll).
REQ-024 If no channel is eligible in ARB (withdrawn via clr_all or ps_pl change), FSM SHALL return to IDLE without offering.
REQ-025 In OFFER, vector and win_id SHALL hold stable until ack, regardless of ps_pl, req or lvl changes.
REQ-026 OFFER & ack SHALL clear latched[win_id] and return to IDLE in the same edge; offer deasserts the next cycle.
REQ-027 ack outside OFFER SHALL be ignored.
REQ-028 req[i] in the same cycle as its ack-clear SHALL leave latched[i] set (set wins).
REQ-029 req on an already-latched channel SHALL be absorbed (no count, one service).
REQ-030 clr_all SHALL clear all latches and force IDLE, overriding simultaneous req and ack.
REQ-031 poll during ARB or OFFER SHALL be ignored.

Reset
REQ-032 On reset: state IDLE, latched=0, offer=0, vector=0, win_id=0; pending therefore 0.
REQ-033 Reset SHALL dominate clr_all, req and ack in the same cycle.

Structure
REQ-034 Shared package SHALL hold the FSM state enum and the vector formatting width constants.
REQ-035 One sub-module prio_pick (combinational NSRC-way max-level/lowest-index picker) SHALL be used; rest is flat.
REQ-036 No behavioural delays or initial blocks; fully synthesizable for NSRC up to 16.

Verification
REQ-037 NSRC=8, ps_pl=4, req[2] lvl 5 vec 'o060>>2, poll -> offer at poll+2, vector='o60, win_id=2; ack -> latched[2]=0.
REQ-038 req[1] lvl 6 and req[5] lvl 6 same cycle, ps_pl=0, poll -> win_id=1; after ack, next poll -> win_id=5.
REQ-039 ps_pl=7, req[3] lvl 7 nmi=0 -> pending=0, poll no offer; set nmi[3]=1 -> pending=1, offer win_id=3.
REQ-040 In OFFER raise ps_pl to 7 and pulse req[0] lvl 7 nmi -> vector/win_id unchanged until ack; then req[0] serviced next poll.
REQ-041 req[4] pulsed on same cycle as ack of channel 4 -> latched[4]=1 after edge; clr_all in OFFER -> offer=0, latched=0, state IDLE.
REQ-042 reset asserted mid-OFFER with req pulses -> all outputs zero the next cycle, no residual latches.

Source files
------------

// File: rtl/trap_arb_pkg.sv
// Shared types and constants for the trap/interrupt arbiter.
//   state_e      : arbiter FSM states
//   VEC_*        : widths that shape the offered 16-bit vector
//   fmt_vector() : place an 8-bit vector field at address bits [9:2]
package trap_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_OFFER = 2'd2
  } state_e;

  localparam int unsigned LVL_W       = 3;
  localparam int unsigned VEC_FIELD_W = 8;
  localparam int unsigned VEC_LO_W    = 2;
  localparam int unsigned VECTOR_W    = 16;
  localparam int unsigned VEC_HI_W    = VECTOR_W - VEC_FIELD_W - VEC_LO_W;

  // Vector field is a word address; pad low bits and zero-extend on top.
  function automatic logic [VECTOR_W-1:0] fmt_vector(input logic [VEC_FIELD_W-1:0] field);
    return {{VEC_HI_W{1'b0}}, field, {VEC_LO_W{1'b0}}};
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational NSRC-way priority picker.
//   elig_i  : per-channel eligibility
//   nmi_i   : per-channel non-maskable flag (outranks any level)
//   lvl_i   : per-channel 3-bit level, channel i at [3i+2:3i]
//   any_c_o : at least one eligible channel
//   idx_c_o : winning index (highest {nmi,lvl}, ties to lowest index)
module prio_pick
  import trap_arb_pkg::*;
#(
  parameter int unsigned NSRC = 8,
  parameter int unsigned IDW  = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]       elig_i,
  input  logic [NSRC-1:0]       nmi_i,
  input  logic [LVL_W*NSRC-1:0] lvl_i,
  output logic                  any_c_o,
  output logic [IDW-1:0]        idx_c_o
);

  logic [LVL_W:0] key;
  logic [LVL_W:0] best_key;

  // Strictly-greater replacement while scanning upward keeps the lowest index on ties.
  always_comb begin
    any_c_o  = 1'b0;
    idx_c_o  = '0;
    best_key = '0;
    key      = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      key = {nmi_i[i], lvl_i[LVL_W*i +: LVL_W]};
      if (elig_i[i] && (!any_c_o || (key > best_key))) begin
        any_c_o  = 1'b1;
        best_key = key;
        idx_c_o  = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/trap_arb.sv
// Trap/interrupt arbiter: latches request pulses, and at a microcode
// service point offers the highest-priority eligible vector until acked.
//   clk, reset : clock, synchronous active-high reset
//   req        : per-channel request pulses (set latches)
//   nmi        : per-channel non-maskable flag
//   lvl        : per-channel level, 3 bits each
//   vec        : per-channel vector field, 8 bits each
//   ps_pl      : processor priority level
//   poll       : service point strobe
//   ack        : offered vector taken
//   clr_all    : bus init, clears latches and returns to idle
//   pending    : any eligible latched channel (combinational)
//   offer      : vector/win_id valid, awaiting ack
//   vector     : offered vector {6'b0, vec[win], 2'b00}
//   win_id     : offered channel index
//   latched    : request latches
module trap_arb
  import trap_arb_pkg::*;
#(
  parameter int unsigned NSRC = 8,
  parameter int unsigned IDW  = $clog2(NSRC)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NSRC-1:0]             req,
  input  logic [NSRC-1:0]             nmi,
  input  logic [LVL_W*NSRC-1:0]       lvl,
  input  logic [VEC_FIELD_W*NSRC-1:0] vec,
  input  logic [LVL_W-1:0]            ps_pl,
  input  logic                        poll,
  input  logic                        ack,
  input  logic                        clr_all,
  output logic                        pending,
  output logic                        offer,
  output logic [VECTOR_W-1:0]         vector,
  output logic [IDW-1:0]              win_id,
  output logic [NSRC-1:0]             latched
);

  state_e              state_q, state_d;
  logic [NSRC-1:0]     latched_q, latched_d;
  logic                offer_q, offer_d;
  logic [VECTOR_W-1:0] vector_q, vector_d;
  logic [IDW-1:0]      win_id_q, win_id_d;

  logic [NSRC-1:0]        elig;
  logic                   pick_any;
  logic [IDW-1:0]         pick_idx;
  logic [VEC_FIELD_W-1:0] pick_vec;
  logic                   ack_take;

  // A latched channel is eligible if non-maskable or above the processor level.
  always_comb begin
    for (int i = 0; i < int'(NSRC); i++) begin
      elig[i] = latched_q[i] & (nmi[i] | (lvl[LVL_W*i +: LVL_W] > ps_pl));
    end
  end

  assign pending = |elig;

  prio_pick #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_pick (
    .elig_i  (elig),
    .nmi_i   (nmi),
    .lvl_i   (lvl),
    .any_c_o (pick_any),
    .idx_c_o (pick_idx)
  );

  // Vector field of the current pick.
  always_comb begin
    pick_vec = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (pick_idx == IDW'(i)) pick_vec = vec[VEC_FIELD_W*i +: VEC_FIELD_W];
    end
  end

  // Next-state: FSM, offer capture and latch update.
  always_comb begin
    state_d   = state_q;
    latched_d = latched_q;
    offer_d   = offer_q;
    vector_d  = vector_q;
    win_id_d  = win_id_q;
    ack_take  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (poll && pending) state_d = ST_ARB;
      end
      ST_ARB: begin
        // Requests may have been withdrawn since the poll; back off quietly.
        if (pick_any) begin
          state_d  = ST_OFFER;
          offer_d  = 1'b1;
          win_id_d = pick_idx;
          vector_d = fmt_vector(pick_vec);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (ack) begin
          ack_take = 1'b1;
          state_d  = ST_IDLE;
          offer_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear the serviced latch first so a same-cycle request re-sets it.
    if (ack_take) latched_d = latched_q & ~(NSRC'(1) << win_id_q);
    latched_d = latched_d | req;

    if (clr_all) begin
      latched_d = '0;
      state_d   = ST_IDLE;
      offer_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      latched_q <= '0;
      offer_q   <= 1'b0;
      vector_q  <= '0;
      win_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      latched_q <= latched_d;
      offer_q   <= offer_d;
      vector_q  <= vector_d;
      win_id_q  <= win_id_d;
    end
  end

  assign offer   = offer_q;
  assign vector  = vector_q;
  assign win_id  = win_id_q;
  assign latched = latched_q;

endmodule

// File: tb/tb_trap_arb.sv
// Self-checking bench for trap_arb (NSRC=8): directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_trap_arb;

  localparam int NSRC = 8;
  localparam int IDW  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NSRC-1:0]  req, nmi;
  logic [3*NSRC-1:0] lvl;
  logic [8*NSRC-1:0] vec;
  logic [2:0]       ps_pl;
  logic             poll, ack, clr_all;
  logic             pending, offer;
  logic [15:0]      vector;
  logic [IDW-1:0]   win_id;
  logic [NSRC-1:0]  latched;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trap_arb #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .nmi     (nmi),
    .lvl     (lvl),
    .vec     (vec),
    .ps_pl   (ps_pl),
    .poll    (poll),
    .ack     (ack),
    .clr_all (clr_all),
    .pending (pending),
    .offer   (offer),
    .vector  (vector),
    .win_id  (win_id),
    .latched (latched)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [NSRC-1:0] m_lat   = '0;
  int            m_stage = 0;   // 0 waiting, 1 arbitrating, 2 offering
  int            m_win   = 0;
  logic [15:0]   m_vec   = '0;

  function automatic void best(output bit any, output int idx);
    int bk;
    int k;
    any = 1'b0;
    idx = 0;
    bk  = -1;
    for (int i = 0; i < NSRC; i++) begin
      if (m_lat[i] && (nmi[i] || (int'(lvl[3*i +: 3]) > int'(ps_pl)))) begin
        k = (nmi[i] ? 8 : 0) + int'(lvl[3*i +: 3]);
        if (k > bk) begin
          bk  = k;
          idx = i;
          any = 1'b1;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    bit any;
    int idx;
    bit [NSRC-1:0] nl;
    best(any, idx);
    if (reset) begin
      m_lat = '0; m_stage = 0; m_win = 0; m_vec = '0;
    end else if (clr_all) begin
      m_lat = '0; m_stage = 0;
    end else begin
      nl = m_lat;
      if (m_stage == 2 && ack) nl[m_win] = 1'b0;
      nl = nl | req;
      case (m_stage)
        0: if (poll && any) m_stage = 1;
        1: if (any) begin
             m_stage = 2;
             m_win   = idx;
             m_vec   = {6'b0, vec[8*idx +: 8], 2'b00};
           end else m_stage = 0;
        2: if (ack) m_stage = 0;
        default: m_stage = 0;
      endcase
      m_lat = nl;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    bit any;
    int idx;
    best(any, idx);
    check("m_pending", 32'(pending), 32'(any));
    check("m_offer",   32'(offer),   32'(m_stage == 2));
    check("m_latched", 32'(latched), 32'(m_lat));
    if (m_stage == 2) begin
      check("m_vector", 32'(vector), 32'(m_vec));
      check("m_win_id", 32'(win_id), 32'(m_win));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_req(input logic [NSRC-1:0] m);
    req = m; tick(); req = '0;
  endtask

  task automatic do_poll();
    poll = 1'b1; tick(); poll = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [2:0] l, input logic [7:0] v);
    lvl[3*ch +: 3] = l;
    vec[8*ch +: 8] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = '0; nmi = '0; lvl = '0; vec = '0;
    ps_pl = 3'd0; poll = 1'b0; ack = 1'b0; clr_all = 1'b0;
    tick(); tick();
    check("rst_offer", 32'(offer), 32'd0);
    check("rst_latched", 32'(latched), 32'd0);
    check("rst_vector", 32'(vector), 32'd0);
    check("rst_win_id", 32'(win_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    reset = 1'b0;
    tick();

    // Basic service: channel 2, level 5 above ps 4, vector 'o60.
    ps_pl = 3'd4;
    set_ch(2, 3'd5, 8'h0C);
    pulse_req(8'h04);
    check("s1_latched", 32'(latched), 32'h04);
    do_poll();
    check("s1_arb_offer", 32'(offer), 32'd0);
    tick();
    check("s1_offer", 32'(offer), 32'd1);
    check("s1_vector", 32'(vector), 32'h0030);
    check("s1_win_id", 32'(win_id), 32'd2);
    do_ack();
    check("s1_ack_latched", 32'(latched), 32'h00);
    check("s1_ack_offer", 32'(offer), 32'd0);

    // Tie at level 6: lower index first, then the other.
    ps_pl = 3'd0;
    set_ch(1, 3'd6, 8'h11);
    set_ch(5, 3'd6, 8'h55);
    pulse_req(8'h22);
    do_poll(); tick();
    check("s2_win_a", 32'(win_id), 32'd1);
    do_ack();
    do_poll(); tick();
    check("s2_win_b", 32'(win_id), 32'd5);
    check("s2_latched", 32'(latched), 32'h20);
    do_ack();

    // Masked by ps 7 until nmi raised.
    ps_pl = 3'd7;
    set_ch(3, 3'd7, 8'h21);
    pulse_req(8'h08);
    #1 check("s3_pending_masked", 32'(pending), 32'd0);
    do_poll(); tick();
    check("s3_no_offer", 32'(offer), 32'd0);
    nmi[3] = 1'b1;
    #1 check("s3_pending_nmi", 32'(pending), 32'd1);
    do_poll(); tick();
    check("s3_offer", 32'(offer), 32'd1);
    check("s3_win_id", 32'(win_id), 32'd3);
    check("s3_vector", 32'(vector), 32'h0084);
    do_ack();

    // Offer holds while ps, lvl, req and poll change underneath it.
    ps_pl = 3'd0;
    set_ch(6, 3'd3, 8'h40);
    pulse_req(8'h40);
    do_poll(); tick();
    check("s4_win6", 32'(win_id), 32'd6);
    check("s4_vec6", 32'(vector), 32'h0100);
    ps_pl = 3'd7;
    set_ch(0, 3'd7, 8'h05);
    nmi[0] = 1'b1;
    lvl[3*6 +: 3] = 3'd0;
    poll = 1'b1;
    pulse_req(8'h01);
    poll = 1'b0;
    tick();
    check("s4_hold_win", 32'(win_id), 32'd6);
    check("s4_hold_vec", 32'(vector), 32'h0100);
    check("s4_hold_offer", 32'(offer), 32'd1);
    check("s4_hold_latched", 32'(latched), 32'h41);
    do_ack();
    check("s4_ack_latched", 32'(latched), 32'h01);
    do_poll(); tick();
    check("s4_win0", 32'(win_id), 32'd0);
    check("s4_vec0", 32'(vector), 32'h0014);
    do_ack();
    nmi = '0;

    // ack outside OFFER ignored; withdrawal during arbitration.
    ps_pl = 3'd0;
    pulse_req(8'h02);
    do_ack();
    check("s5_ack_idle", 32'(latched), 32'h02);
    do_poll();
    ps_pl = 3'd7;
    tick();
    check("s5_withdrawn", 32'(offer), 32'd0);
    tick();
    check("s5_still_idle", 32'(offer), 32'd0);
    ps_pl = 3'd0;
    clr_all = 1'b1; tick(); clr_all = 1'b0;
    check("s5_clr", 32'(latched), 32'h00);

    // Set wins over ack-clear; clr_all overrides req and ack in OFFER.
    set_ch(4, 3'd2, 8'h10);
    pulse_req(8'h10);
    do_poll(); tick();
    check("s6_win4", 32'(win_id), 32'd4);
    ack = 1'b1; req = 8'h10;
    tick();
    ack = 1'b0; req = '0;
    check("s6_set_wins", 32'(latched), 32'h10);
    check("s6_offer_off", 32'(offer), 32'd0);
    do_poll(); tick();
    check("s6_reoffer", 32'(offer), 32'd1);
    check("s6_revec", 32'(vector), 32'h0040);
    pulse_req(8'h02);
    clr_all = 1'b1; req = 8'h04; ack = 1'b1;
    tick();
    clr_all = 1'b0; req = '0; ack = 1'b0;
    check("s6_clr_offer", 32'(offer), 32'd0);
    check("s6_clr_latched", 32'(latched), 32'h00);
    do_poll(); tick();
    check("s6_idle", 32'(offer), 32'd0);

    // Reset mid-OFFER dominates req, ack and clr_all.
    set_ch(7, 3'd4, 8'hFF);
    pulse_req(8'h80);
    do_poll(); tick();
    check("s7_offer", 32'(offer), 32'd1);
    check("s7_vec", 32'(vector), 32'h03FC);
    reset = 1'b1; req = 8'hFF; ack = 1'b1; clr_all = 1'b1;
    tick();
    reset = 1'b0; req = '0; ack = 1'b0; clr_all = 1'b0;
    check("s7_offer0", 32'(offer), 32'd0);
    check("s7_vector0", 32'(vector), 32'd0);
    check("s7_win0", 32'(win_id), 32'd0);
    check("s7_latched0", 32'(latched), 32'd0);
    #1 check("s7_pending0", 32'(pending), 32'd0);
    tick();
    check("s7_no_residue", 32'(latched), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
